// File: rtl/key_debounce.sv
// Debounces N_KEYS active-low push-buttons into active-high levels with one-cycle press/release pulses.
// Optional release pulses are built only when KEY_DEBOUNCE_RELEASE_EN is defined; otherwise released is tied to 0.
module key_debounce #(
   parameter int N_KEYS        = 4,
   parameter int STABLE_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key,
   output logic [N_KEYS-1:0] level,
   output logic [N_KEYS-1:0] pressed,
   output logic [N_KEYS-1:0] released,
   output logic              any_pressed
);

   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

   generate
      if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
         $error("key_debounce: STABLE_CYCLES must be at least 2");
      end
   endgenerate

   logic [N_KEYS-1:0]         s1_q, s1_d;
   logic [N_KEYS-1:0]         s2_q, s2_d;
   logic [N_KEYS-1:0]         level_q, level_d;
   logic [N_KEYS-1:0]         pressed_q, pressed_d;
   logic [N_KEYS-1:0][CW-1:0] cnt_q, cnt_d;

   always_comb begin
      s1_d    = ~key;
      s2_d    = s1_q;
      level_d = level_q;
      cnt_d   = cnt_q;
      // The counter saturates at CNT_MAX by committing the level, so it can never wrap.
      for (int i = 0; i < N_KEYS; i++) begin
         if (s2_q[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            level_d[i] = s2_q[i];
            cnt_d[i]   = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
      pressed_d = level_d & ~level_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q      <= '0;
         s2_q      <= '0;
         level_q   <= '0;
         pressed_q <= '0;
         cnt_q     <= '0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         level_q   <= level_d;
         pressed_q <= pressed_d;
         cnt_q     <= cnt_d;
      end
   end

`ifdef KEY_DEBOUNCE_RELEASE_EN
   logic [N_KEYS-1:0] released_q, released_d;

   always_comb begin
      released_d = level_q & ~level_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         released_q <= '0;
      end else begin
         released_q <= released_d;
      end
   end

   assign released = released_q;
`else
   assign released = '0;
`endif

   assign level       = level_q;
   assign pressed     = pressed_q;
   assign any_pressed = |level_q;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with N_KEYS=4, STABLE_CYCLES=4: each edge's expected outputs are queued as stimulus is driven.
module tb_key_debounce;

   localparam int NK = 4;
   localparam int SC = 4;
   localparam int LAT = SC + 2;
`ifdef KEY_DEBOUNCE_RELEASE_EN
   localparam bit REL_EN = 1'b1;
`else
   localparam bit REL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [NK-1:0] lvl;
      logic [NK-1:0] prs;
      logic [NK-1:0] rel;
      logic          any;
   } obs_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [NK-1:0] key;
   logic [NK-1:0] level, pressed, released;
   logic          any_pressed;

   obs_t exp_q[$];
   obs_t got, want;
   int   n_pass = 0;
   int   n_total = 0;

   key_debounce #(.N_KEYS(NK), .STABLE_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .key(key), .level(level), .pressed(pressed),
      .released(released), .any_pressed(any_pressed)
   );

   always #5 clk = ~clk;

   function automatic obs_t mk(input logic [NK-1:0] l, input logic [NK-1:0] p, input logic [NK-1:0] r);
      mk.lvl = l;
      mk.prs = p;
      mk.rel = REL_EN ? r : '0;
      mk.any = |l;
   endfunction

   // Expected output after edge e of a clean level change on mask m from level l0.
   function automatic obs_t change_exp(input int e, input logic [NK-1:0] l0, input logic [NK-1:0] m, input bit rise);
      logic [NK-1:0] l1;
      l1 = rise ? (l0 | m) : (l0 & ~m);
      if (e < LAT)       change_exp = mk(l0, '0, '0);
      else if (e == LAT) change_exp = mk(l1, rise ? m : '0, rise ? '0 : m);
      else               change_exp = mk(l1, '0, '0);
   endfunction

   task automatic test_reset();
      for (int e = 1; e <= 2; e++) begin
         rst = 1'b1; key = 4'b0000;
         exp_q.push_back(mk('0, '0, '0));
         @(posedge clk); @(negedge clk);
         got = {level, pressed, released, any_pressed}; want = exp_q.pop_front(); n_total++;
         if (got !== want) $display("FAIL reset_hold e=%0d got=%h want=%h", e, got, want); else n_pass++;
      end
      for (int e = 1; e <= 8; e++) begin
         rst = 1'b0; key = 4'b0000;
         exp_q.push_back(change_exp(e, 4'h0, 4'hF, 1'b1));
         @(posedge clk); @(negedge clk);
         got = {level, pressed, released, any_pressed}; want = exp_q.pop_front(); n_total++;
         if (got !== want) $display("FAIL reset_release_press e=%0d got=%h want=%h", e, got, want); else n_pass++;
      end
      for (int e = 1; e <= 8; e++) begin
         key = 4'b1111;
         exp_q.push_back(change_exp(e, 4'hF, 4'hF, 1'b0));
         @(posedge clk); @(negedge clk);
         got = {level, pressed, released, any_pressed}; want = exp_q.pop_front(); n_total++;
         if (got !== want) $display("FAIL all_release e=%0d got=%h want=%h", e, got, want); else n_pass++;
      end
   endtask

   task automatic test_press();
      for (int e = 1; e <= 10; e++) begin
         key = 4'b1101;
         exp_q.push_back(change_exp(e, 4'h0, 4'b0010, 1'b1));
         @(posedge clk); @(negedge clk);
         got = {level, pressed, released, any_pressed}; want = exp_q.pop_front(); n_total++;
         if (got !== want) $display("FAIL press_k1 e=%0d got=%h want=%h", e, got, want); else n_pass++;
      end
   endtask

   task automatic test_release();
      for (int e = 1; e <= 8; e++) begin
         key = 4'b1111;
         exp_q.push_back(change_exp(e, 4'b0010, 4'b0010, 1'b0));
         @(posedge clk); @(negedge clk);
         got = {level, pressed, released, any_pressed}; want = exp_q.pop_front(); n_total++;
         if (got !== want) $display("FAIL release_k1 e=%0d got=%h want=%h", e, got, want); else n_pass++;
      end
   endtask

   task automatic test_bounce();
      for (int e = 1; e <= 14; e++) begin
         key = ((e >= 1 && e <= 3) || (e >= 5 && e <= 7)) ? 4'b1011 : 4'b1111;
         exp_q.push_back(mk('0, '0, '0));
         @(posedge clk); @(negedge clk);
         got = {level, pressed, released, any_pressed}; want = exp_q.pop_front(); n_total++;
         if (got !== want) $display("FAIL bounce_k2 e=%0d got=%h want=%h", e, got, want); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_count();
      for (int e = 1; e <= 4; e++) begin
         key = 4'b1110;
         rst = (e == 4);
         exp_q.push_back(mk('0, '0, '0));
         @(posedge clk); @(negedge clk);
         got = {level, pressed, released, any_pressed}; want = exp_q.pop_front(); n_total++;
         if (got !== want) $display("FAIL midcount_pre e=%0d got=%h want=%h", e, got, want); else n_pass++;
      end
      for (int e = 1; e <= 8; e++) begin
         rst = 1'b0; key = 4'b1110;
         exp_q.push_back(change_exp(e, 4'h0, 4'b0001, 1'b1));
         @(posedge clk); @(negedge clk);
         got = {level, pressed, released, any_pressed}; want = exp_q.pop_front(); n_total++;
         if (got !== want) $display("FAIL midcount_post e=%0d got=%h want=%h", e, got, want); else n_pass++;
      end
      for (int e = 1; e <= 8; e++) begin
         key = 4'b1111;
         exp_q.push_back(change_exp(e, 4'b0001, 4'b0001, 1'b0));
         @(posedge clk); @(negedge clk);
         got = {level, pressed, released, any_pressed}; want = exp_q.pop_front(); n_total++;
         if (got !== want) $display("FAIL midcount_release e=%0d got=%h want=%h", e, got, want); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      for (int e = 1; e <= 8; e++) begin
         key = 4'b0110;
         exp_q.push_back(change_exp(e, 4'h0, 4'b1001, 1'b1));
         @(posedge clk); @(negedge clk);
         got = {level, pressed, released, any_pressed}; want = exp_q.pop_front(); n_total++;
         if (got !== want) $display("FAIL simul_press e=%0d got=%h want=%h", e, got, want); else n_pass++;
      end
      for (int e = 1; e <= 8; e++) begin
         key = 4'b1111;
         exp_q.push_back(change_exp(e, 4'b1001, 4'b1001, 1'b0));
         @(posedge clk); @(negedge clk);
         got = {level, pressed, released, any_pressed}; want = exp_q.pop_front(); n_total++;
         if (got !== want) $display("FAIL simul_release e=%0d got=%h want=%h", e, got, want); else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1;
      key = 4'b0000;
      @(negedge clk);
      test_reset();
      test_press();
      test_release();
      test_bounce();
      test_reset_mid_count();
      test_back_to_back();
      n_total++;
      if (exp_q.size() !== 0) $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size()); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
